rom_dump_uart: RTL and testbench

//  Downstream of the ROM reader. Captures (address, data) samples read from a 556PT5/556PT4

---
 rtl/rom_dump_uart.sv | 221 ++++++++++++++++++++++
 tb/tb_rom_dump_uart.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_dump_uart.sv
// ROM sample capture FIFO feeding an 8N1 UART that sends ADDR_HI, ADDR_LO, DATA per record.
// Define ROM_DUMP_CHECKSUM_EN to append an XOR checksum byte to every record.
module rom_dump_uart #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9,
    parameter int FIFO_DEPTH    = 4,
    parameter int CLKS_PER_BIT  = 434
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sample_valid,
    input  logic [ADDRESS_WIDTH-1:0] sample_addr,
    input  logic [DATA_WIDTH-1:0]    sample_data,
    output logic                     sample_ready,
    output logic                     uart_tx,
    output logic                     busy,
    output logic                     overflow
);

    localparam int REC_W = ADDRESS_WIDTH + DATA_WIDTH;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef ROM_DUMP_CHECKSUM_EN
    localparam int NUM_BYTES = 4;
`else
    localparam int NUM_BYTES = 3;
`endif
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [1:0]       LAST_BYTE  = 2'(NUM_BYTES - 1);

    if (DATA_WIDTH < 1 || DATA_WIDTH > 8) begin : g_bad_data_width
        $error("rom_dump_uart: DATA_WIDTH must be in 1..8");
    end
    if (ADDRESS_WIDTH < 1 || ADDRESS_WIDTH > 16) begin : g_bad_addr_width
        $error("rom_dump_uart: ADDRESS_WIDTH must be in 1..16");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rom_dump_uart: FIFO_DEPTH must be a power of 2, >= 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("rom_dump_uart: CLKS_PER_BIT must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t             state_reg, state_next;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic [2:0]         bit_reg, bit_next;
    logic [1:0]         byte_idx_reg, byte_idx_next;
    logic               tx_reg, tx_next;
    logic               tick;

    logic [REC_W-1:0]   mem [FIFO_DEPTH];
    logic [REC_W-1:0]   shadow_reg;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               overflow_reg;
    logic               full, empty, push, pop;

    logic [15:0]        addr16;
    logic [7:0]         data8;
    logic [7:0]         cur_byte;

    assign full  = (count_reg == COUNT_FULL);
    assign empty = (count_reg == '0);
    assign pop   = (state_reg == ST_IDLE) && !empty;

    // A pop in the same cycle frees a slot, so a full FIFO can still take a record then.
    assign sample_ready = reset_n && (!full || pop);
    assign push         = sample_valid && sample_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {sample_addr, sample_data};
        end
        if (pop) begin
            shadow_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (sample_valid && !sample_ready) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Zero-extend the captured record to the 16-bit address / 8-bit data wire format.
    for (genvar gi = 0; gi < 16; gi++) begin : g_addr16
        if (gi < ADDRESS_WIDTH) begin : g_bit
            assign addr16[gi] = shadow_reg[DATA_WIDTH + gi];
        end else begin : g_zero
            assign addr16[gi] = 1'b0;
        end
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_data8
        if (gi < DATA_WIDTH) begin : g_bit
            assign data8[gi] = shadow_reg[gi];
        end else begin : g_zero
            assign data8[gi] = 1'b0;
        end
    end

    always_comb begin
        cur_byte = 8'h00;
        case (byte_idx_next)
            2'd0:    cur_byte = addr16[15:8];
            2'd1:    cur_byte = addr16[7:0];
            2'd2:    cur_byte = data8;
`ifdef ROM_DUMP_CHECKSUM_EN
            default: cur_byte = addr16[15:8] ^ addr16[7:0] ^ data8;
`else
            default: cur_byte = 8'h00;
`endif
        endcase
    end

    assign tick = (timer_reg == TMR_LAST);

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        bit_next      = bit_reg;
        byte_idx_next = byte_idx_reg;
        case (state_reg)
            ST_IDLE: begin
                timer_next = '0;
                bit_next   = '0;
                if (!empty) begin
                    byte_idx_next = '0;
                    state_next    = ST_START;
                end
            end
            ST_START: begin
                timer_next = tick ? '0 : timer_reg + TMR_W'(1);
                if (tick) begin
                    bit_next   = '0;
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                timer_next = tick ? '0 : timer_reg + TMR_W'(1);
                if (tick) begin
                    if (bit_reg == 3'd7) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                timer_next = tick ? '0 : timer_reg + TMR_W'(1);
                if (tick) begin
                    if (byte_idx_reg == LAST_BYTE) begin
                        state_next = ST_IDLE;
                    end else begin
                        byte_idx_next = byte_idx_reg + 2'd1;
                        state_next    = ST_START;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The line level is registered from the next state so uart_tx never glitches.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = cur_byte[bit_next];
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            timer_reg    <= '0;
            bit_reg      <= '0;
            byte_idx_reg <= '0;
            tx_reg       <= 1'b1;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            bit_reg      <= bit_next;
            byte_idx_reg <= byte_idx_next;
            tx_reg       <= tx_next;
        end
    end

    assign uart_tx  = tx_reg;
    assign busy     = (state_reg != ST_IDLE) || !empty;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_rom_dump_uart.sv
// Bench for rom_dump_uart: directed and random records checked against a record-level model
// of FIFO occupancy and the serial timeline, with a UART decoder on the line.
module tb_rom_dump_uart;

    localparam int C     = 4;
    localparam int DEPTH = 4;
`ifdef ROM_DUMP_CHECKSUM_EN
    localparam int NF = 4;
`else
    localparam int NF = 3;
`endif
    localparam int REC_CYC = NF * 10 * C;

    logic       clk          = 1'b0;
    logic       reset_n      = 1'b0;
    logic       sample_valid = 1'b0;
    logic [8:0] sample_addr  = '0;
    logic [7:0] sample_data  = '0;
    logic       sample_ready, uart_tx, busy, overflow;

    logic       valid_n = 1'b0;
    logic [7:0] addr_n  = '0;
    logic [3:0] data_n  = '0;
    logic       ready_n, tx_n, busy_n, overflow_n;

    always #5 clk = ~clk;

    rom_dump_uart #(.DATA_WIDTH(8), .ADDRESS_WIDTH(9), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(C)) dut (
        .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_addr(sample_addr),
        .sample_data(sample_data), .sample_ready(sample_ready), .uart_tx(uart_tx),
        .busy(busy), .overflow(overflow)
    );

    rom_dump_uart #(.DATA_WIDTH(4), .ADDRESS_WIDTH(8), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(C)) dut_narrow (
        .clk(clk), .reset_n(reset_n), .sample_valid(valid_n), .sample_addr(addr_n),
        .sample_data(data_n), .sample_ready(ready_n), .uart_tx(tx_n),
        .busy(busy_n), .overflow(overflow_n)
    );

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } rec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   armed    = 0;

    rec_t mq[$];
    int   idle_at    = 0;
    bit   ovf_m      = 0;
    int   last_start = 0;
    logic [7:0] exp_b[$];
    int   exp_s[$];

    logic [7:0] rx_b[$];
    int   rx_s[$];
    bit   rx_ok_q[$];
    bit   rx_act = 0;
    int   rx_t   = 0;
    int   rx_st  = 0;
    logic [7:0] rx_byte = '0;
    bit   rx_ok  = 1;

    bit         nv = 0;
    logic [7:0] na = '0;
    logic [3:0] nd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void exp_record(input int start, input logic [15:0] a16, input logic [7:0] d8);
        logic [7:0] b [4];
        b[0] = 8'(a16 >> 8);
        b[1] = 8'(a16 & 16'h00FF);
        b[2] = d8;
        b[3] = b[0] ^ b[1] ^ b[2];
        for (int k = 0; k < NF; k++) begin
            exp_b.push_back(b[k]);
            exp_s.push_back(start + k * 10 * C);
        end
    endfunction

    // UART receiver: samples each bit in its middle, stamps frames with their start cycle.
    task automatic mon_sample(input logic tx);
        int k;
        if (rx_act) begin
            rx_t++;
        end else if (tx === 1'b0) begin
            rx_act  = 1;
            rx_t    = 0;
            rx_st   = cyc;
            rx_ok   = 1;
            rx_byte = '0;
        end
        if (rx_act) begin
            if (rx_t % C == C / 2) begin
                k = rx_t / C;
                if (k == 0) rx_ok &= (tx === 1'b0);
                else if (k <= 8) rx_byte[k-1] = tx;
                else rx_ok &= (tx === 1'b1);
            end
            if (rx_t == 10 * C - 1) begin
                rx_b.push_back(rx_byte);
                rx_s.push_back(rx_st);
                rx_ok_q.push_back(rx_ok);
                rx_act = 0;
            end
        end
    endtask

    task automatic step(input bit v, input logic [8:0] a, input logic [7:0] d, input bit rst);
        bit   pop_m, rdy_m, busy_m;
        rec_t r;
        @(negedge clk);
        reset_n      = !rst;
        sample_valid = v;
        sample_addr  = a;
        sample_data  = d;
        valid_n      = nv;
        addr_n       = na;
        data_n       = nd;
        #1;
        pop_m  = (cyc >= idle_at) && (mq.size() > 0);
        rdy_m  = !rst && ((mq.size() < DEPTH) || pop_m);
        busy_m = (mq.size() > 0) || (cyc < idle_at);
        check("sample_ready", sample_ready, rdy_m);
        if (armed) begin
            check("busy", busy, busy_m);
            check("overflow", overflow, ovf_m);
            mon_sample(uart_tx & tx_n);
        end
        if (rst) begin
            mq.delete();
            idle_at = 0;
            ovf_m   = 0;
            exp_b.delete();
            exp_s.delete();
            rx_b.delete();
            rx_s.delete();
            rx_ok_q.delete();
            rx_act = 0;
        end else begin
            if (pop_m) begin
                r          = mq.pop_front();
                last_start = cyc + 1;
                exp_record(cyc + 1, r.a, r.d);
                idle_at    = cyc + 1 + REC_CYC;
            end
            if (v && rdy_m) begin
                r.a = 16'(a);
                r.d = d;
                mq.push_back(r);
            end else if (v) begin
                ovf_m = 1;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, '0, 0);
    endtask

    task automatic do_reset();
        step(0, '0, '0, 1);
        step(0, '0, '0, 0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((mq.size() > 0 || cyc < idle_at || rx_act) && n < budget) begin
            step(0, '0, '0, 0);
            n++;
        end
        check("drain_within_budget", (n < budget), 1);
        step(0, '0, '0, 0);
        check("busy_after_drain", busy, 0);
    endtask

    task automatic compare(input string tag);
        check({tag, "_frame_count"}, rx_b.size(), exp_b.size());
        for (int i = 0; i < rx_b.size() && i < exp_b.size(); i++) begin
            check({tag, "_byte"}, rx_b[i], exp_b[i]);
            check({tag, "_start_cycle"}, rx_s[i], exp_s[i]);
            check({tag, "_framing"}, rx_ok_q[i], 1);
        end
        exp_b.delete();
        exp_s.delete();
        rx_b.delete();
        rx_s.delete();
        rx_ok_q.delete();
    endtask

    initial begin
        int p, n, g;
        bit pp;
        int pct;

        // Reset state
        step(0, '0, '0, 1);
        armed = 1;
        step(0, '0, '0, 1);
        step(0, '0, '0, 1);
        check("reset_uart_tx", uart_tx, 1);
        check("reset_busy", busy, 0);
        check("reset_overflow", overflow, 0);
        step(0, '0, '0, 0);
        check("ready_after_release", sample_ready, 1);

        // Single record
        p = cyc;
        step(1, 9'h1A5, 8'h3C, 0);
        drain(600);
        if (rx_b.size() >= 3) begin
            check("single_byte0", rx_b[0], 8'h01);
            check("single_byte1", rx_b[1], 8'hA5);
            check("single_byte2", rx_b[2], 8'h3C);
            check("single_start_latency", rx_s[0], p + 2);
        end
        compare("single");

        // Overflow: six back-to-back offers from idle
        for (int i = 0; i < 6; i++) step(1, 9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)), 0);
        step(0, '0, '0, 0);
        check("overflow_set", overflow, 1);
        drain(2000);
        check("overflow_records", rx_b.size(), 5 * NF);
        check("overflow_sticky", overflow, 1);
        compare("overflow");

        // Full FIFO: push accepted only in the pop cycle
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)), 0);
        n = 0;
        g = 0;
        while (n < 2 && g < 1000) begin
            pp = (cyc >= idle_at) && (mq.size() > 0);
            step(pp, 9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)), 0);
            if (pp) begin
                check("full_pushpop_ready", sample_ready, 1);
                n++;
            end
            g++;
        end
        check("full_pushpop_count", n, 2);
        drain(3000);
        check("full_pushpop_no_overflow", overflow, 0);
        compare("full_pushpop");

        // Narrow chip on the second instance
        nv = 1;
        na = 8'hFF;
        nd = 4'hF;
        p  = cyc;
        step(0, '0, '0, 0);
        check("narrow_ready", ready_n, 1);
        nv = 0;
        exp_record(p + 2, 16'h00FF, 8'h0F);
        idle(REC_CYC + 6);
        check("narrow_busy_after", busy_n, 0);
        if (rx_b.size() >= 3) begin
            check("narrow_byte0", rx_b[0], 8'h00);
            check("narrow_byte1", rx_b[1], 8'hFF);
            check("narrow_byte2", rx_b[2], 8'h0F);
        end
        compare("narrow");

        // Reset during data bit 3 of byte1 with two records queued
        for (int i = 0; i < 3; i++) step(1, 9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)), 0);
        g = 0;
        while (cyc < last_start + 14 * C + 1 && g < 500) begin
            step(0, '0, '0, 0);
            g++;
        end
        step(0, '0, '0, 1);
        step(0, '0, '0, 0);
        check("midframe_reset_tx", uart_tx, 1);
        check("midframe_reset_busy", busy, 0);
        check("midframe_reset_overflow", overflow, 0);
        idle(300);
        compare("midframe_reset");

        // Back-to-back records
        for (int i = 0; i < 3; i++) step(1, 9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)), 0);
        drain(2000);
        check("b2b_records", rx_b.size(), 3 * NF);
        if (rx_s.size() >= NF + 1) begin
            check("b2b_contiguous", rx_s[1] - rx_s[0], 10 * C);
            check("b2b_record_gap", rx_s[NF] - rx_s[NF-1], 10 * C + 1);
        end
        compare("b2b");

        // Random traffic at a light and a heavy offer rate
        do_reset();
        for (int ph = 0; ph < 2; ph++) begin
            pct = (ph == 0) ? 2 : 60;
            for (int i = 0; i < 1500; i++) begin
                step(($urandom_range(0, 99) < pct), 9'($urandom_range(0, 511)), 8'($urandom_range(0, 255)), 0);
            end
        end
        drain(4000);
        compare("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
